// File: rtl/slice_output_arbiter.sv
// Merges per-slice output-buffer beat streams into one raster-order picture stream with
// line/frame markers. Optional stall counter enabled by defining SLICE_ARB_UNDERFLOW_CNT_EN.
module slice_output_arbiter #(
  parameter int unsigned NUM_SLICES       = 4,
  parameter int unsigned MAX_SLICE_WIDTH  = 2560,
  parameter int unsigned MAX_FRAME_HEIGHT = 4096
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sof,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]    slice_width,
  input  logic [$clog2(NUM_SLICES):0]           slices_per_line,
  input  logic [$clog2(MAX_FRAME_HEIGHT):0]     frame_height,
  input  logic [NUM_SLICES-1:0]                 in_valid,
  input  logic [NUM_SLICES*168-1:0]             in_data_p,
  output logic [NUM_SLICES-1:0]                 in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [167:0]                          out_data_p,
  output logic                                  out_sol,
  output logic                                  out_eol,
  output logic                                  out_sof,
  output logic                                  out_eof,
  output logic                                  frame_done,
  output logic [15:0]                           underflow_cnt
);

  localparam int unsigned PixW  = 168;
  localparam int unsigned SwW   = $clog2(MAX_SLICE_WIDTH);
  localparam int unsigned SumW  = SwW + 1;
  localparam int unsigned SplW  = $clog2(NUM_SLICES) + 1;
  localparam int unsigned FhW   = $clog2(MAX_FRAME_HEIGHT) + 1;
  localparam int unsigned SIdxW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int unsigned BeatW = $clog2((MAX_SLICE_WIDTH + 3) / 4 + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q;
  logic [BeatW-1:0]    beats_q, beat_cnt_q;
  logic [SIdxW-1:0]    last_slice_q, slice_idx_q;
  logic [FhW-1:0]      frame_height_q, line_cnt_q;
  logic                out_valid_q, out_sol_q, out_eol_q, out_sof_q, out_eof_q;
  logic [PixW-1:0]     out_data_q;
  logic                frame_done_q;

  logic                adv, xfer, sel_valid;
  logic [PixW-1:0]     sel_data;
  logic                first_beat, beat_last, slice_last, line_last;
  logic [SplW-1:0]     spl_eff;
  logic [SIdxW-1:0]    last_cfg;
  logic [BeatW-1:0]    beats_cfg;

  assign adv = ~out_valid_q | out_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (SIdxW'(s) == slice_idx_q) begin
        sel_valid   = in_valid[s];
        sel_data    = in_data_p[s*PixW +: PixW];
        in_ready[s] = (state_q == StRun) & adv;
      end
    end
  end

  assign xfer       = (state_q == StRun) & adv & sel_valid;
  assign first_beat = (slice_idx_q == '0) & (beat_cnt_q == '0);
  assign beat_last  = (beat_cnt_q == beats_q - 1'b1);
  assign slice_last = (slice_idx_q == last_slice_q);
  assign line_last  = (line_cnt_q == frame_height_q - 1'b1);

  // Zero active slices behaves as one; anything beyond the slice count is clamped.
  always_comb begin
    spl_eff = slices_per_line;
    if (slices_per_line == '0) begin
      spl_eff = SplW'(1);
    end else if (slices_per_line > SplW'(NUM_SLICES)) begin
      spl_eff = SplW'(NUM_SLICES);
    end
  end

  assign last_cfg  = SIdxW'(spl_eff - SplW'(1));
  assign beats_cfg = BeatW'(({1'b0, slice_width} + SumW'(3)) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      beats_q        <= '0;
      last_slice_q   <= '0;
      frame_height_q <= '0;
      beat_cnt_q     <= '0;
      slice_idx_q    <= '0;
      line_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sol_q      <= 1'b0;
      out_eol_q      <= 1'b0;
      out_sof_q      <= 1'b0;
      out_eof_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else if (sof) begin
      // A new frame wins over everything, including a beat being granted this cycle.
      beats_q        <= beats_cfg;
      last_slice_q   <= last_cfg;
      frame_height_q <= frame_height;
      beat_cnt_q     <= '0;
      slice_idx_q    <= '0;
      line_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sol_q      <= 1'b0;
      out_eol_q      <= 1'b0;
      out_sof_q      <= 1'b0;
      out_eof_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      state_q        <= (frame_height == '0) ? StDone : StRun;
    end else begin
      frame_done_q <= 1'b0;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_sol_q   <= first_beat;
        out_eol_q   <= slice_last & beat_last;
        out_sof_q   <= first_beat & (line_cnt_q == '0);
        out_eof_q   <= slice_last & beat_last & line_last;
        if (beat_last) begin
          beat_cnt_q <= '0;
          if (slice_last) begin
            slice_idx_q <= '0;
            line_cnt_q  <= line_cnt_q + 1'b1;
            if (line_last) state_q <= StDone;
          end else begin
            slice_idx_q <= slice_idx_q + 1'b1;
          end
        end else begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_sol_q   <= 1'b0;
        out_eol_q   <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end
      if (state_q == StDone) begin
        frame_done_q <= 1'b1;
        state_q      <= StIdle;
      end
    end
  end

`ifdef SLICE_ARB_UNDERFLOW_CNT_EN
  logic [15:0] underflow_q;

  // Counts cycles where the output could take a beat but the selected slice had none.
  always_ff @(posedge clk) begin
    if (rst || sof) begin
      underflow_q <= '0;
    end else if ((state_q == StRun) && adv && !sel_valid && (underflow_q != 16'hFFFF)) begin
      underflow_q <= underflow_q + 1'b1;
    end
  end

  assign underflow_cnt = underflow_q;
`else
  assign underflow_cnt = '0;
`endif

  assign out_valid  = out_valid_q;
  assign out_data_p = out_data_q;
  assign out_sol    = out_sol_q;
  assign out_eol    = out_eol_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_slice_output_arbiter.sv
// Directed bench for slice_output_arbiter: each slice source tags beats with {slice, index}
// so the merged stream order and markers can be checked against hand-derived sequences.
module tb_slice_output_arbiter;

  logic         clk = 1'b0;
  logic         rst, sof, out_ready, ptr_clr;
  logic [11:0]  slice_width;
  logic [2:0]   slices_per_line;
  logic [12:0]  frame_height;
  logic [3:0]   in_valid, in_ready;
  logic [671:0] in_data_p;
  logic         out_valid, out_sol, out_eol, out_sof, out_eof, frame_done;
  logic [167:0] out_data_p;
  logic [15:0]  underflow_cnt;
  logic [15:0]  ptr [4];

  typedef struct {
    logic [7:0]  sl;
    logic [15:0] idx;
    logic [3:0]  mk;   // {sol, eol, sof, eof}
    int          cyc;
  } beat_t;

  beat_t q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  slice_output_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .sof             (sof),
    .slice_width     (slice_width),
    .slices_per_line (slices_per_line),
    .frame_height    (frame_height),
    .in_valid        (in_valid),
    .in_data_p       (in_data_p),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data_p      (out_data_p),
    .out_sol         (out_sol),
    .out_eol         (out_eol),
    .out_sof         (out_sof),
    .out_eof         (out_eof),
    .frame_done      (frame_done),
    .underflow_cnt   (underflow_cnt)
  );

  // Slice sources: each advances its beat index when the beat is taken.
  always @(posedge clk) begin
    for (int s = 0; s < 4; s++) begin
      if (ptr_clr) ptr[s] <= '0;
      else if (in_valid[s] && in_ready[s]) ptr[s] <= ptr[s] + 16'd1;
    end
  end

  always_comb begin
    in_data_p = '0;
    for (int s = 0; s < 4; s++) in_data_p[s*168 +: 24] = {8'(s), ptr[s]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int spl, input int fh);
    sof             = 1'b1;
    ptr_clr         = 1'b1;
    slice_width     = 12'(w);
    slices_per_line = 3'(spl);
    frame_height    = 13'(fh);
    tick();
    sof     = 1'b0;
    ptr_clr = 1'b0;
  endtask

  task automatic capture(input int cyc);
    beat_t b;
    if (out_valid && out_ready) begin
      b.sl  = out_data_p[23:16];
      b.idx = out_data_p[15:0];
      b.mk  = {out_sol, out_eol, out_sof, out_eof};
      b.cyc = cyc;
      q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sof = 1'b0; ptr_clr = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
    slice_width = 12'd16; slices_per_line = 3'd2; frame_height = 13'd2;
    tick();
    tick();
    rst = 1'b0; ptr_clr = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 4'h0) begin
      errors++; $display("FAIL reset_in_ready: got %h want 0", in_ready);
    end
    checks++;
    if ({out_data_p, out_sol, out_eol, out_sof, out_eof, frame_done} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", out_data_p);
    end
    checks++;
    if (underflow_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_underflow: got %0d want 0", underflow_cnt);
    end
    tick();
    checks++;
    if (in_ready !== 4'h0) begin
      errors++; $display("FAIL idle_in_ready: got %h want 0", in_ready);
    end
  endtask

  // 2 slices x 4 beats x 2 lines, no stalls.
  task automatic test_basic();
    int fd_n = 0;
    int fd_cyc = -1;
    logic [7:0]  esl;
    logic [15:0] eidx;
    logic [3:0]  emk;
    q.delete();
    in_valid = 4'hF; out_ready = 1'b1;
    start_frame(16, 2, 2);
    for (int c = 0; c < 30; c++) begin
      #1;
      capture(c);
      if (frame_done) begin fd_n++; fd_cyc = c; end
      tick();
    end
    checks++;
    if (q.size() != 16) begin
      errors++; $display("FAIL basic_count: got %0d want 16", q.size());
    end
    for (int k = 0; k < q.size() && k < 16; k++) begin
      esl  = 8'((k / 4) % 2);
      eidx = 16'(k % 4 + 4 * (k / 8));
      emk  = {(k == 0 || k == 8), (k == 7 || k == 15), (k == 0), (k == 15)};
      checks++;
      if (q[k].sl !== esl || q[k].idx !== eidx) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %0h/%0h want %0h/%0h", k, q[k].sl, q[k].idx,
                 esl, eidx);
      end
      checks++;
      if (q[k].mk !== emk) begin
        errors++; $display("FAIL basic_markers[%0d]: got %b want %b", k, q[k].mk, emk);
      end
    end
    if (q.size() == 16) begin
      checks++;
      if (q[0].cyc != 1 || q[15].cyc != 16) begin
        errors++;
        $display("FAIL basic_timing: got first %0d last %0d want 1 16", q[0].cyc, q[15].cyc);
      end
    end
    checks++;
    if (fd_n != 1 || fd_cyc != 17) begin
      errors++; $display("FAIL basic_frame_done: got n=%0d cyc=%0d want n=1 cyc=17", fd_n, fd_cyc);
    end
  endtask

  // slice_width=10 rounds up to 3 beats; 3 slices, single line.
  task automatic test_width10();
    int fd_n = 0;
    logic [3:0] emk;
    q.delete();
    in_valid = 4'hF; out_ready = 1'b1;
    start_frame(10, 3, 1);
    for (int c = 0; c < 20; c++) begin
      #1;
      capture(c);
      if (frame_done) fd_n++;
      tick();
    end
    checks++;
    if (q.size() != 9) begin
      errors++; $display("FAIL w10_count: got %0d want 9", q.size());
    end
    for (int k = 0; k < q.size() && k < 9; k++) begin
      emk = {(k == 0), (k == 8), (k == 0), (k == 8)};
      checks++;
      if (q[k].sl !== 8'(k / 3) || q[k].idx !== 16'(k % 3) || q[k].mk !== emk) begin
        errors++;
        $display("FAIL w10_beat[%0d]: got %0h/%0h/%b want %0h/%0h/%b", k, q[k].sl, q[k].idx,
                 q[k].mk, k / 3, k % 3, emk);
      end
    end
    checks++;
    if (fd_n != 1) begin
      errors++; $display("FAIL w10_frame_done: got %0d pulses want 1", fd_n);
    end
  endtask

  // out_ready low for 5 cycles while beat 3 is presented.
  task automatic test_backpressure();
    logic [167:0] ref_data;
    logic [3:0]   ref_mk;
    logic [3:0]   emk;
    q.delete();
    in_valid = 4'hF;
    start_frame(16, 2, 1);
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c < 9);
      #1;
      if (c == 4) begin
        ref_data = out_data_p;
        ref_mk   = {out_sol, out_eol, out_sof, out_eof};
        checks++;
        if (!out_valid || ref_data[23:0] !== 24'h000003 || ref_mk !== 4'b0000) begin
          errors++;
          $display("FAIL bp_held_beat: got v=%b %h mk=%b want v=1 000003 mk=0000", out_valid,
                   ref_data[23:0], ref_mk);
        end
      end else if (c > 4 && c < 9) begin
        checks++;
        if (!out_valid || out_data_p !== ref_data ||
            {out_sol, out_eol, out_sof, out_eof} !== ref_mk) begin
          errors++;
          $display("FAIL bp_stable[%0d]: got v=%b %h want v=1 %h", c, out_valid,
                   out_data_p[23:0], ref_data[23:0]);
        end
      end
      if (c >= 4 && c < 9) begin
        checks++;
        if (in_ready !== 4'h0) begin
          errors++; $display("FAIL bp_in_ready[%0d]: got %h want 0", c, in_ready);
        end
      end
      capture(c);
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d want 8", q.size());
    end
    for (int k = 0; k < q.size() && k < 8; k++) begin
      emk = {(k == 0), (k == 7), (k == 0), (k == 7)};
      checks++;
      if (q[k].sl !== 8'(k / 4) || q[k].idx !== 16'(k % 4) || q[k].mk !== emk) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got %0h/%0h/%b want %0h/%0h/%b", k, q[k].sl, q[k].idx,
                 q[k].mk, k / 4, k % 4, emk);
      end
    end
  endtask

  // Slice 1 runs dry for 4 cycles while it is selected; slice 0 must not be granted.
  task automatic test_underflow();
    logic [15:0] exp_uf;
    q.delete();
    out_ready = 1'b1;
    in_valid  = 4'hF;
    start_frame(16, 2, 1);
    for (int c = 0; c < 30; c++) begin
      in_valid = (c >= 4 && c < 8) ? 4'b1101 : 4'b1111;
      #1;
      if (c >= 4 && c < 8) begin
        checks++;
        if (in_ready !== 4'b0010) begin
          errors++; $display("FAIL uf_in_ready[%0d]: got %b want 0010", c, in_ready);
        end
      end
      capture(c);
      tick();
    end
    in_valid = 4'hF;
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL uf_count: got %0d want 8", q.size());
    end else begin
      checks++;
      if (q[4].sl !== 8'd1 || q[4].idx !== 16'd0 || q[4].cyc != 9) begin
        errors++;
        $display("FAIL uf_resume: got %0h/%0h at %0d want 1/0 at 9", q[4].sl, q[4].idx,
                 q[4].cyc);
      end
      checks++;
      if (q[7].sl !== 8'd1 || q[7].idx !== 16'd3 || q[7].mk !== 4'b0101) begin
        errors++;
        $display("FAIL uf_last: got %0h/%0h/%b want 1/3/0101", q[7].sl, q[7].idx, q[7].mk);
      end
    end
`ifdef SLICE_ARB_UNDERFLOW_CNT_EN
    exp_uf = 16'd4;
`else
    exp_uf = 16'd0;
`endif
    checks++;
    if (underflow_cnt !== exp_uf) begin
      errors++; $display("FAIL uf_cnt: got %0d want %0d", underflow_cnt, exp_uf);
    end
  endtask

  // New sof at line 1 beat 2 with one slice per line.
  task automatic test_sof_midframe();
    int bad = 0;
    q.delete();
    in_valid = 4'hF; out_ready = 1'b1;
    start_frame(16, 2, 2);
    for (int c = 0; c < 11; c++) tick();
    checks++;
    if (!out_valid || out_data_p[23:0] !== 24'h000006) begin
      errors++;
      $display("FAIL mid_pre: got v=%b %h want v=1 000006", out_valid, out_data_p[23:0]);
    end
    start_frame(16, 1, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_cleared: got %b want 0", out_valid);
    end
    for (int c = 0; c < 15; c++) begin
      #1;
      if (in_ready[3:1] !== 3'b000) bad++;
      capture(c);
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_other_grant: got %0d cycles want 0", bad);
    end
    checks++;
    if (q.size() != 4) begin
      errors++; $display("FAIL mid_count: got %0d want 4", q.size());
    end
    for (int k = 0; k < q.size() && k < 4; k++) begin
      checks++;
      if (q[k].sl !== 8'd0 || q[k].idx !== 16'(k) ||
          q[k].mk !== {(k == 0), (k == 3), (k == 0), (k == 3)}) begin
        errors++;
        $display("FAIL mid_beat[%0d]: got %0h/%0h/%b want 0/%0h", k, q[k].sl, q[k].idx,
                 q[k].mk, k);
      end
    end
  endtask

  task automatic test_zero_height();
    in_valid = 4'hF; out_ready = 1'b1;
    start_frame(16, 2, 0);
    #1;
    checks++;
    if (in_ready !== 4'h0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL zh_c0: got rdy=%h fd=%b want 0 0", in_ready, frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 4'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zh_c1: got fd=%b rdy=%h v=%b want 1 0 0", frame_done, in_ready, out_valid);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || in_ready !== 4'h0) begin
      errors++; $display("FAIL zh_c2: got fd=%b rdy=%h want 0 0", frame_done, in_ready);
    end
  endtask

  task automatic test_rst_midrun();
    in_valid = 4'hF; out_ready = 1'b1;
    start_frame(16, 2, 2);
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got %b want 1", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data_p, out_sol, out_eol, out_sof, out_eof, frame_done} !== '0) begin
      errors++; $display("FAIL rst_outputs: got v=%b %h want 0", out_valid, out_data_p[23:0]);
    end
    checks++;
    if (in_ready !== 4'h0 || underflow_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_ready: got %h/%0d want 0/0", in_ready, underflow_cnt);
    end
    tick();
    checks++;
    if (in_ready !== 4'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_idle: got %h/%b want 0/0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width10();
    test_backpressure();
    test_underflow();
    test_sof_midframe();
    test_zero_height();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
